// File: rtl/overlay_pkg.sv
// Shared layout, text-grid and prefetch-FSM definitions for the debug overlay.
package overlay_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_REQ     = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;

  // Text grid: 8-pixel columns, 16-pixel rows.
  localparam int COL_SHIFT = 3;
  localparam int ROW_SHIFT = 4;

  localparam int FIELD_ROW0      = 2;
  localparam int FIELD_COL0      = 2;
  localparam int FIELD_ROW_PITCH = 3;
  localparam int FIELD_GAP       = 2;
  localparam int DUMP_ROW0       = 14;
  localparam int DUMP_COL0       = 2;

  function automatic int digit_count(input int width, input int hex_mode);
    return (hex_mode != 0) ? width / 4 : width;
  endfunction

endpackage

// File: rtl/overlay_digit_select.sv
// Picks one displayed digit out of a value, most significant digit at index 0.
module overlay_digit_select #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 4
) (
  input  logic [DATA_WIDTH-1:0] value_i,
  input  logic [IDX_W-1:0]      digit_idx_i,
  input  logic                  hex_mode_i,
  output logic [3:0]            digit_o
);

  logic [DATA_WIDTH-1:0] shifted;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    shifted = '0;
    digit_o = '0;
    if (hex_mode_i) begin
      shifted = value_i >> (4 * (DATA_WIDTH / 4 - 1 - int'(digit_idx_i)));
      digit_o = shifted[3:0];
    end else begin
      shifted = value_i >> (DATA_WIDTH - 1 - int'(digit_idx_i));
      digit_o = {3'b000, shifted[0]};
    end
  end

endmodule

// File: rtl/debug_overlay_engine.sv
// Register/memory-dump text overlay: snapshots values at frame start, prefetches
// one memory word per dump row and emits digits through a 2-stage pixel pipeline.
module debug_overlay_engine
  import overlay_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_FIELDS    = 8,
  parameter int DUMP_ROWS     = 10,
  parameter int ADDRESS_WIDTH = 16,
  parameter int HEX_MODE      = 0
) (
  input  logic                                  clock_in,
  input  logic                                  reset_in,
  input  logic [9:0]                            pixel_x_in,
  input  logic [9:0]                            pixel_y_in,
  input  logic                                  video_on_in,
  input  logic                                  v_sync_in,
  input  logic [NUM_FIELDS-1:0][DATA_WIDTH-1:0] fields_in,
  input  logic [ADDRESS_WIDTH-1:0]              dump_base_in,
  output logic [ADDRESS_WIDTH-1:0]              mem_address_out,
  input  logic [DATA_WIDTH-1:0]                 mem_data_in,
  output logic [3:0]                            digit_out,
  output logic                                  bit_value_out,
  output logic                                  char_valid_out
);

  localparam int DIGITS = digit_count(DATA_WIDTH, HEX_MODE);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                                  v_sync_q;
  logic                                  snap_valid_q;
  logic [NUM_FIELDS-1:0][DATA_WIDTH-1:0] fields_snap_q;
  logic [ADDRESS_WIDTH-1:0]              dump_base_snap_q;
  logic                                  vsync_fall;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0]    row_buf_q, row_buf_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_value_q, s1_value_d;
  logic [IDX_W-1:0]      s1_idx_q, s1_idx_d;
  logic [3:0]            sel_digit;
  logic [3:0]            digit_q;
  logic                  valid_q;

  logic [9-COL_SHIFT:0]     text_col;
  logic [9-ROW_SHIFT:0]     text_row;
  logic                     dump_hit;
  logic                     row_start;
  logic [ADDRESS_WIDTH-1:0] row_offset;
  logic [ADDRESS_WIDTH-1:0] dump_row_addr;

  assign text_col      = pixel_x_in[9:COL_SHIFT];
  assign text_row      = pixel_y_in[9:ROW_SHIFT];
  assign dump_hit      = (int'(text_row) >= DUMP_ROW0) && (int'(text_row) < DUMP_ROW0 + DUMP_ROWS);
  assign row_start     = (pixel_x_in == 10'd0) && (pixel_y_in[ROW_SHIFT-1:0] == '0);
  assign row_offset    = ADDRESS_WIDTH'(int'(text_row) - DUMP_ROW0);
  assign dump_row_addr = dump_base_snap_q + row_offset;
  assign vsync_fall    = v_sync_q & ~v_sync_in;

  // NOTE: snapshot registers are plain flops, so they can and must be reset like any other state.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      v_sync_q         <= 1'b0;
      snap_valid_q     <= 1'b0;
      fields_snap_q    <= '0;
      dump_base_snap_q <= '0;
    end else begin
      v_sync_q <= v_sync_in;
      if (vsync_fall) begin
        snap_valid_q     <= 1'b1;
        fields_snap_q    <= fields_in;
        dump_base_snap_q <= dump_base_in;
      end
    end
  end

  // The address is latched on entry to REQ, so a coincident snapshot cannot alter it.
  always_comb begin
    state_d       = state_q;
    mem_address_d = mem_address_q;
    row_buf_d     = row_buf_q;
    case (state_q)
      ST_IDLE: begin
        if (row_start && dump_hit && snap_valid_q) begin
          state_d       = ST_REQ;
          mem_address_d = dump_row_addr;
        end
      end
      ST_REQ:     state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        row_buf_d = mem_data_in;
        state_d   = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q       <= ST_IDLE;
      mem_address_q <= '0;
      row_buf_q     <= '0;
    end else begin
      state_q       <= state_d;
      mem_address_q <= mem_address_d;
      row_buf_q     <= row_buf_d;
    end
  end

  // Stage 1 region decode; fields are scanned last and high-to-low so lower k wins.
  always_comb begin
    s1_valid_d = 1'b0;
    s1_value_d = '0;
    s1_idx_d   = '0;
    if (dump_hit) begin
      if (int'(text_col) >= DUMP_COL0 && int'(text_col) < DUMP_COL0 + DIGITS) begin
        s1_valid_d = 1'b1;
        s1_value_d = DATA_WIDTH'(dump_row_addr);
        s1_idx_d   = IDX_W'(int'(text_col) - DUMP_COL0);
      end else if (int'(text_col) >= DUMP_COL0 + DIGITS + FIELD_GAP &&
                   int'(text_col) <  DUMP_COL0 + 2 * DIGITS + FIELD_GAP) begin
        s1_valid_d = 1'b1;
        s1_value_d = row_buf_q;
        s1_idx_d   = IDX_W'(int'(text_col) - DUMP_COL0 - DIGITS - FIELD_GAP);
      end
    end
    for (int k = NUM_FIELDS - 1; k >= 0; k--) begin
      if (int'(text_row) == FIELD_ROW0 + FIELD_ROW_PITCH * (k / 2) &&
          int'(text_col) >= FIELD_COL0 + (k % 2) * (DIGITS + FIELD_GAP) &&
          int'(text_col) <  FIELD_COL0 + (k % 2) * (DIGITS + FIELD_GAP) + DIGITS) begin
        s1_valid_d = 1'b1;
        s1_value_d = fields_snap_q[k];
        s1_idx_d   = IDX_W'(int'(text_col) - FIELD_COL0 - (k % 2) * (DIGITS + FIELD_GAP));
      end
    end
    if (!snap_valid_q) s1_value_d = '0;
    if (!video_on_in)  s1_valid_d = 1'b0;
  end

  overlay_digit_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_digit_select (
    .value_i     (s1_value_q),
    .digit_idx_i (s1_idx_q),
    .hex_mode_i  (HEX_MODE != 0),
    .digit_o     (sel_digit)
  );

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      s1_valid_q <= 1'b0;
      s1_value_q <= '0;
      s1_idx_q   <= '0;
      digit_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_value_q <= s1_valid_d ? s1_value_d : '0;
      s1_idx_q   <= s1_idx_d;
      digit_q    <= s1_valid_q ? sel_digit : 4'd0;
      valid_q    <= s1_valid_q;
    end
  end

  assign mem_address_out = mem_address_q;
  assign digit_out       = digit_q;
  assign bit_value_out   = digit_q[0];
  assign char_valid_out  = valid_q;

endmodule

// File: doc/debug_overlay_engine.md
DEBUG_OVERLAY_ENGINE -- requirements
Module: debug_overlay_engine

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH (default 16, value width in bits); NUM_FIELDS (default 8, register fields shown); DUMP_ROWS (default 10, memory dump rows); ADDRESS_WIDTH (default 16, memory address width); HEX_MODE (default 0; 0 = binary digits, 1 = hex digits).
REQ-002 Ports SHALL be: clock_in  input  1  pixel clock; single clock domain.
REQ-003 reset_in  input  1  synchronous, active-high reset.
REQ-004 pixel_x_in  input  10  and  pixel_y_in  input  10  current pixel from vga_sync.
REQ-005 video_on_in  input  1  display-active flag; v_sync_in  input  1  vertical sync, active low.
REQ-006 fields_in  input  NUM_FIELDS x DATA_WIDTH  live register values (PC, IR, ACC, ...).
REQ-007 dump_base_in  input  ADDRESS_WIDTH  first memory address of the dump table.
REQ-008 mem_address_out  output  ADDRESS_WIDTH  memory read address; mem_data_in  input  DATA_WIDTH  read data, valid exactly 1 cycle after address.
REQ-009 digit_out  output  4  digit value for the character generator; bit_value_out  output  1  equals digit_out[0]; char_valid_out  output  1  pixel lies inside a digit cell.

Function
REQ-010 Text grid: 8-pixel columns (pixel_x[9:3]), 16-pixel rows (pixel_y[9:4]).
REQ-011 DIGITS = DATA_WIDTH (binary) or DATA_WIDTH/4 (hex, DATA_WIDTH multiple of 4 required); leftmost digit SHALL be most significant.
REQ-012 Field k SHALL occupy text row FIELD_ROW0 + 3*(k/2), columns FIELD_COL0 + (k%2)*(DIGITS+2) through that + DIGITS-1.
REQ-013 Dump table: text rows DUMP_ROW0 .. DUMP_ROW0+DUMP_ROWS-1; address column at DUMP_COL0, data column at DUMP_COL0+DIGITS+2; row r shows address dump_base_snap + r and its memory word.
REQ-014 Frame snapshot: on the cycle v_sync_in goes 1->0, fields_in and dump_base_in SHALL be captured; the whole next frame displays only snapshotted values (no tearing).
REQ-015 Row prefetch FSM states IDLE, REQ, CAPTURE: in IDLE, when pixel_x_in == 0 and pixel_y_in[3:0] == 0 on a dump row r -> REQ, drive mem_address_out = dump_base_snap + r -> CAPTURE next cycle, latch mem_data_in into row buffer -> IDLE.
REQ-016 mem_address_out SHALL hold its last value outside REQ; address arithmetic SHALL wrap modulo 2^ADDRESS_WIDTH.
REQ-017 Output pipeline latency SHALL be exactly 2 cycles from pixel_x_in/pixel_y_in to digit_out/char_valid_out (stage 1 region decode, stage 2 digit select), matching the font_rom path.
REQ-018 Outside all digit cells, or with video_on_in low (delayed with the pipeline), digit_out = 0, bit_value_out = 0, char_valid_out = 0.
REQ-019 Overlapping regions: fields take priority over dump table; lower k wins among fields.
REQ-020 Snapshot edge coinciding with a prefetch: prefetch completes using the pre-snapshot base.

Reset
REQ-021 While reset_in high: FSM -> IDLE, snapshots and row buffer -> 0, mem_address_out = 0, all pipeline registers and outputs = 0.
REQ-022 Reset mid-frame SHALL display zeros until the next v_sync falling edge; no partial prefetch result is kept.

Structure
REQ-023 Package overlay_pkg SHALL hold the FSM state typedef, FIELD_ROW0/FIELD_COL0/DUMP_ROW0/DUMP_COL0 layout constants and the grid shift constants.
REQ-024 One sub-module overlay_digit_select (value, digit index, mode -> 4-bit digit) SHALL be used for fields, addresses and data.

Verification
REQ-025 Binary, field 0 = 16'h0001 snapshotted: pixel in last digit cell -> 2 cycles later digit_out = 1, char_valid_out = 1; other 15 cells -> 0.
REQ-026 HEX_MODE = 1, field 3 = 16'hA5C3: four digit cells output A, 5, C, 3 left to right.
REQ-027 dump_base_in = 16'hFFFE, DUMP_ROWS = 4: addresses shown FFFE, FFFF, 0000, 0001; mem_address_out pulses same values one per row start.
REQ-028 Change fields_in mid-frame: display unchanged until after the next v_sync falling edge.
REQ-029 Assert reset_in for 1 cycle mid-frame: all outputs 0 next cycle; values reappear only after next snapshot.
REQ-030 video_on_in low over a digit cell: char_valid_out = 0, digit_out = 0.
